// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported, fixed-latency memory between the
//                fetch port (I, reads only) and the data port (D, reads and
//                writes). Simultaneous requests alternate between the ports.
//                Each access is issued as a one-cycle strobe. The block counts
//                out the memory latency and returns registered read data with
//                a one-cycle acknowledge.
//
//  Ports       : clk, rst             clock, asynchronous active-high reset
//                i_req/i_addr         fetch request (held until i_ack)
//                i_ack/i_rdata        fetch acknowledge pulse and read data
//                i_stall              i_req & ~i_ack
//                d_req/d_we/d_addr/d_wdata  data request (held until d_ack)
//                d_ack/d_rdata        data acknowledge pulse and read data
//                d_stall              d_req & ~d_ack
//                mem_en/mem_we        one-cycle access strobes to the memory
//                mem_addr/mem_wdata   registered access address / write data
//                mem_rdata            memory data, valid MEM_LAT cycles after
//                                     the mem_en cycle
//                busy                 high whenever the block is not IDLE
//
//  Parameters  : ADDR_W, DATA_W, MEM_LAT (legal range 1..15)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic       c_PORT_I = 1'b0;
    localparam logic       c_PORT_D = 1'b1;
    localparam logic [3:0] c_LAT    = 4'(MEM_LAT);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t              r_state;
    logic                r_last_grant;   // port granted most recently
    logic                r_port;         // port owning the current access
    logic                r_we;           // current access is a write
    logic [3:0]          r_cnt;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_i_ack;
    logic                r_d_ack;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    // Next-state values
    state_t              w_state_nxt;
    logic                w_last_grant_nxt;
    logic                w_port_nxt;
    logic                w_we_nxt;
    logic [3:0]          w_cnt_nxt;
    logic                w_mem_en_nxt;
    logic                w_mem_we_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic                w_i_ack_nxt;
    logic                w_d_ack_nxt;
    logic [DATA_W-1:0]   w_i_rdata_nxt;
    logic [DATA_W-1:0]   w_d_rdata_nxt;

    // Arbitration: D wins when it is alone, or on a tie when I was granted last.
    logic w_grant_d;
    logic w_grant_i;
    logic w_owner_req;

    assign w_grant_d   = d_req & (~i_req | (r_last_grant == c_PORT_I));
    assign w_grant_i   = i_req & ~w_grant_d;
    assign w_owner_req = (r_port == c_PORT_D) ? d_req : i_req;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_PORT_I;
            r_port       <= c_PORT_I;
            r_we         <= 1'b0;
            r_cnt        <= 4'd0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_i_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_port       <= w_port_nxt;
            r_we         <= w_we_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_i_ack      <= w_i_ack_nxt;
            r_d_ack      <= w_d_ack_nxt;
            r_i_rdata    <= w_i_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_port_nxt       = r_port;
        w_we_nxt         = r_we;
        w_cnt_nxt        = r_cnt;
        w_mem_en_nxt     = 1'b0;
        w_mem_we_nxt     = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_i_ack_nxt      = 1'b0;
        w_d_ack_nxt      = 1'b0;
        w_i_rdata_nxt    = r_i_rdata;
        w_d_rdata_nxt    = r_d_rdata;

        unique case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_port_nxt       = c_PORT_D;
                    w_we_nxt         = d_we;
                    w_mem_addr_nxt   = d_addr;
                    w_mem_wdata_nxt  = d_wdata;
                    w_mem_en_nxt     = 1'b1;
                    w_mem_we_nxt     = d_we;
                    w_cnt_nxt        = c_LAT;
                    w_last_grant_nxt = c_PORT_D;
                    w_state_nxt      = S_ACCESS;
                end else if (w_grant_i) begin
                    // Fetches never write; the write-data register is left alone.
                    w_port_nxt       = c_PORT_I;
                    w_we_nxt         = 1'b0;
                    w_mem_addr_nxt   = i_addr;
                    w_mem_en_nxt     = 1'b1;
                    w_cnt_nxt        = c_LAT;
                    w_last_grant_nxt = c_PORT_I;
                    w_state_nxt      = S_ACCESS;
                end
            end

            S_ACCESS: begin
                // The counter is loaded with MEM_LAT on the grant edge, so it
                // reads zero exactly in the cycle mem_rdata is valid
                // (MEM_LAT cycles after the mem_en cycle).
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else if (w_owner_req) begin
                    if (!r_we) begin
                        if (r_port == c_PORT_D) w_d_rdata_nxt = mem_rdata;
                        else                    w_i_rdata_nxt = mem_rdata;
                    end
                    if (r_port == c_PORT_D) w_d_ack_nxt = 1'b1;
                    else                    w_i_ack_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    // Requester withdrew (e.g. flushed fetch): drop silently.
                    w_state_nxt = S_IDLE;
                end
            end

            S_DONE: begin
                // Ack cycle: the acked requester may still show req here,
                // so no grant is made until IDLE.
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_stall   = i_req & ~r_i_ack;
    assign d_stall   = d_req & ~r_d_ack;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A cycle table
//                covers a single fetch and a data write, hand sequences cover
//                tie-break, contention, fetch abort and reset mid-access, and
//                a randomized phase checks returned data against a reference
//                memory plus a fairness bound on the alternation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int NTXN = 60;

    logic        clk, rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_tot++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Memory with fixed read latency. Data is only valid in the cycle
    // LAT cycles after the strobe; otherwise the bus carries noise.
    // ------------------------------------------------------------------
    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic        pv [16];
    logic [31:0] pa [16];

    always @(negedge clk) begin
        for (int k = 15; k > 0; k--) begin
            pv[k] = pv[k-1];
            pa[k] = pa[k-1];
        end
        pv[0] = mem_en && !mem_we;
        pa[0] = mem_addr;
        if (mem_en && mem_we) mem[mem_addr[5:2]] = mem_wdata;
        if (pv[LAT]) mem_rdata = mem[pa[LAT][5:2]];
        else         mem_rdata = $urandom;
    end

    // ------------------------------------------------------------------
    // Cycle runner: logs acks, drops a request after its ack and
    // re-raises it one cycle later while re-arms remain.
    // ------------------------------------------------------------------
    int log_p[$];
    int log_c[$];
    int i_pend, d_pend;

    task automatic run_cycles(input int ncyc);
        logic ia, da;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            ia = i_ack;
            da = d_ack;
            if (ia) begin log_p.push_back(0); log_c.push_back(n); end
            if (da) begin log_p.push_back(1); log_c.push_back(n); end
            next();
            if (ia) i_req = 1'b0;
            else if (!i_req && i_pend > 0) begin i_req = 1'b1; i_pend--; end
            if (da) d_req = 1'b0;
            else if (!d_req && d_pend > 0) begin d_req = 1'b1; d_pend--; end
        end
    endtask

    // ------------------------------------------------------------------
    // Cycle table
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [6:0]  flags;   // {i_ack,d_ack,mem_en,mem_we,busy,i_stall,d_stall}
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] ird;
        logic [31:0] drd;
    } vec_t;

    function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                                logic [31:0] da, logic [31:0] dwd, logic [6:0] f,
                                logic [31:0] ma, logic [31:0] mw,
                                logic [31:0] ird, logic [31:0] drd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.flags = f; v.maddr = ma; v.mwdata = mw; v.ird = ird; v.drd = drd;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Randomized phase
    // ------------------------------------------------------------------
    logic done;
    int   i_oth, d_oth;

    task automatic drv_i();
        int w;
        for (int t = 0; t < NTXN; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            i_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            i_req  = 1'b1;
            w = 0;
            do begin @(negedge clk); w++; end while (!i_ack && w < 60);
            if (!i_ack) fail_now("rand_i_ack_timeout");
            next();
            i_req = 1'b0;
        end
    endtask

    task automatic drv_d();
        int w;
        for (int t = 0; t < NTXN; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            d_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            d_we    = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
            d_req   = 1'b1;
            w = 0;
            do begin @(negedge clk); w++; end while (!d_ack && w < 60);
            if (!d_ack) fail_now("rand_d_ack_timeout");
            next();
            d_req = 1'b0;
        end
    endtask

    task automatic monitor();
        while (!done) begin
            @(negedge clk);
            chk("rand_i_stall", 160'(i_stall), 160'(i_req && !i_ack));
            chk("rand_d_stall", 160'(d_stall), 160'(d_req && !d_ack));
            if (mem_we && !mem_en) fail_now("rand_mem_we_without_en");
            if (i_ack) begin
                chk("rand_i_rdata", 160'(i_rdata), 160'(ref_mem[i_addr[5:2]]));
                if (i_oth > 1) chk("rand_i_fairness", 160'(i_oth), 160'(1));
                i_oth = 0;
            end
            if (d_ack) begin
                if (d_we) ref_mem[d_addr[5:2]] = d_wdata;
                else      chk("rand_d_rdata", 160'(d_rdata), 160'(ref_mem[d_addr[5:2]]));
                if (d_oth > 1) chk("rand_d_fairness", 160'(d_oth), 160'(1));
                d_oth = 0;
            end
            if (d_ack && i_req && !i_ack) i_oth++;
            if (i_ack && d_req && !d_ack) d_oth++;
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    vec_t tbl[12];

    initial begin
        logic acc;
        for (int k = 0; k < 16; k++) begin
            mem[k] = 32'hA000_0000 | k;
            pv[k]  = 1'b0;
            pa[k]  = '0;
        end
        mem[4] = 32'h200a_0005;
        mem[3] = 32'hCAFE_0003;
        for (int k = 0; k < 16; k++) ref_mem[k] = mem[k];

        // Single fetch (rows 0-5), then a data write (rows 6-11).
        tbl[0]  = mk(1, 32'h10, 0, 0, 0, 0, 7'b0000010, 0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h10, 0, 0, 0, 0, 7'b0010110, 32'h10, 0, 0, 0);
        tbl[2]  = mk(1, 32'h10, 0, 0, 0, 0, 7'b0000110, 32'h10, 0, 0, 0);
        tbl[3]  = mk(1, 32'h10, 0, 0, 0, 0, 7'b0000110, 32'h10, 0, 0, 0);
        tbl[4]  = mk(1, 32'h10, 0, 0, 0, 0, 7'b1000100, 32'h10, 0, 32'h200a0005, 0);
        tbl[5]  = mk(0, 32'h10, 0, 0, 0, 0, 7'b0000000, 32'h10, 0, 32'h200a0005, 0);
        tbl[6]  = mk(0, 0, 1, 1, 32'h8, 32'h12, 7'b0000001, 32'h10, 0, 32'h200a0005, 0);
        tbl[7]  = mk(0, 0, 1, 1, 32'h8, 32'h12, 7'b0011101, 32'h8, 32'h12, 32'h200a0005, 0);
        tbl[8]  = mk(0, 0, 1, 1, 32'h8, 32'h12, 7'b0000101, 32'h8, 32'h12, 32'h200a0005, 0);
        tbl[9]  = mk(0, 0, 1, 1, 32'h8, 32'h12, 7'b0000101, 32'h8, 32'h12, 32'h200a0005, 0);
        tbl[10] = mk(0, 0, 1, 1, 32'h8, 32'h12, 7'b0100100, 32'h8, 32'h12, 32'h200a0005, 0);
        tbl[11] = mk(0, 0, 0, 0, 32'h8, 32'h12, 7'b0000000, 32'h8, 32'h12, 32'h200a0005, 0);

        rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        i_pend = 0; d_pend = 0; done = 1'b0; i_oth = 0; d_oth = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            160'({i_ack, d_ack, mem_en, mem_we, busy, i_stall, d_stall, mem_addr, mem_wdata, i_rdata, d_rdata}),
            160'(0));
        next();
        rst = 1'b0;

        for (int r = 0; r < 12; r++) begin
            i_req = tbl[r].ir; i_addr = tbl[r].ia;
            d_req = tbl[r].dr; d_we = tbl[r].dw; d_addr = tbl[r].da; d_wdata = tbl[r].dwd;
            @(negedge clk);
            chk($sformatf("table_row%0d", r),
                160'({i_ack, d_ack, mem_en, mem_we, busy, i_stall, d_stall,
                      mem_addr, mem_wdata, i_rdata, d_rdata}),
                160'({tbl[r].flags, tbl[r].maddr, tbl[r].mwdata, tbl[r].ird, tbl[r].drd}));
            next();
        end
        ref_mem[2] = 32'h12;

        // Tie right after reset: D first (ack C4), then I (ack C9).
        rst = 1'b1; i_req = 0; d_req = 0;
        @(negedge clk);
        next();
        rst = 1'b0;
        i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h8;
        log_p.delete(); log_c.delete();
        run_cycles(14);
        chk("tie_ack_count", 160'(log_p.size()), 160'(2));
        if (log_p.size() == 2) begin
            chk("tie_first_port_d", 160'({log_p[0], log_c[0]}), 160'({32'd1, 32'd4}));
            chk("tie_second_port_i", 160'({log_p[1], log_c[1]}), 160'({32'd0, 32'd9}));
        end
        chk("tie_d_rdata", 160'(d_rdata), 160'(32'h12));
        chk("tie_i_rdata", 160'(i_rdata), 160'(32'h200a0005));

        // Continuous contention: four transactions, strict alternation.
        i_req = 1; d_req = 1; i_pend = 1; d_pend = 1;
        log_p.delete(); log_c.delete();
        run_cycles(30);
        chk("contention_ack_count", 160'(log_p.size()), 160'(4));
        if (log_p.size() == 4)
            chk("contention_order_DIDI",
                160'({log_p[0], log_p[1], log_p[2], log_p[3]}),
                160'({32'd1, 32'd0, 32'd1, 32'd0}));

        // Fetch abort: i_req dropped in C2, then a data read raised in C4.
        i_req = 1; i_addr = 32'h14;                       // C0
        @(negedge clk); next();                            // C1
        @(negedge clk);
        chk("abort_issue", 160'({mem_en, mem_addr}), 160'({1'b1, 32'h14}));
        next(); i_req = 0;                                 // C2
        @(negedge clk); acc = i_ack; next();               // C3
        @(negedge clk); acc = acc | i_ack; next();         // C4
        d_req = 1; d_we = 0; d_addr = 32'hC;
        @(negedge clk); acc = acc | i_ack;
        chk("abort_no_ack", 160'(acc), 160'(0));
        chk("abort_idle_c4", 160'(busy), 160'(0));
        chk("abort_i_rdata_kept", 160'(i_rdata), 160'(32'h200a0005));
        next();                                            // C5
        log_p.delete(); log_c.delete();
        run_cycles(8);
        chk("abort_d_ack_count", 160'(log_p.size()), 160'(1));
        if (log_p.size() == 1)
            chk("abort_d_ack_c8", 160'({log_p[0], log_c[0]}), 160'({32'd1, 32'd3}));
        chk("abort_d_rdata", 160'(d_rdata), 160'(32'hCAFE0003));

        // Reset in the middle of a write access.
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h5A5A1234;  // C0
        @(negedge clk); next();                                         // C1
        @(negedge clk);
        chk("midrst_issue", 160'({mem_en, mem_we}), 160'(2'b11));
        next();                                                         // C2
        #2 rst = 1'b1;
        #1;
        chk("midrst_async_clear",
            160'({busy, mem_en, mem_we, i_ack, d_ack, mem_addr}), 160'(0));
        d_req = 0;
        @(negedge clk);
        rst = 1'b0;
        next();
        log_p.delete(); log_c.delete();
        run_cycles(10);
        chk("midrst_no_ack", 160'(log_p.size()), 160'(0));
        chk("midrst_idle", 160'(busy), 160'(0));
        ref_mem[8] = 32'h5A5A1234;

        // Randomized contention against the reference memory.
        fork
            begin
                fork
                    drv_i();
                    drv_d();
                join
                done = 1'b1;
            end
            monitor();
        join

        for (int k = 0; k < 16; k++)
            chk($sformatf("final_mem_word%0d", k), 160'(mem[k]), 160'(ref_mem[k]));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
`default_nettype wire
